// File: rtl/periferico_raiz_param_if.sv
// Bus bundle for the square-root peripheral: chip select, strobes,
// byte address, and 32-bit write and read data.
interface periferico_raiz_param_if #(
    parameter int ANCHO_DIR = 5
);
    logic [31:0]          entrada_datos;
    logic                 habilitar;
    logic [ANCHO_DIR-1:0] direccion;
    logic                 leer;
    logic                 escribir;
    logic [31:0]          salida_datos;

    modport master (
        output entrada_datos,
        output habilitar,
        output direccion,
        output leer,
        output escribir,
        input  salida_datos
    );

    modport slave (
        input  entrada_datos,
        input  habilitar,
        input  direccion,
        input  leer,
        input  escribir,
        output salida_datos
    );
endinterface

// File: rtl/periferico_raiz_param.sv
// Memory-mapped integer square-root peripheral, restoring, 2 bits per edge.
// Optional RAIZ_IRQ_EN adds the irq port, irq_hab and W1C on ESTADO.
module periferico_raiz_param #(
    parameter int ANCHO     = 32,
    parameter int ANCHO_DIR = 5
) (
    input  logic                  reloj,
    input  logic                  reiniciar,
    periferico_raiz_param_if.slave bus
`ifdef RAIZ_IRQ_EN
    ,
    output logic                  irq
`endif
);
    localparam int H  = ANCHO / 2;
    localparam int CW = $clog2(H + 1);

    localparam logic [ANCHO_DIR-1:0] DIR_VALOR = ANCHO_DIR'('h04);
    localparam logic [ANCHO_DIR-1:0] DIR_CTRL  = ANCHO_DIR'('h0C);
    localparam logic [ANCHO_DIR-1:0] DIR_RES   = ANCHO_DIR'('h10);
    localparam logic [ANCHO_DIR-1:0] DIR_EST   = ANCHO_DIR'('h14);
    localparam logic [ANCHO_DIR-1:0] DIR_RESTO = ANCHO_DIR'('h18);

    typedef enum logic {
        REPOSO,
        CALCULO
    } estado_e;

    estado_e          estado_q, estado_d;
    logic [ANCHO-1:0] valor_q, valor_d;
    logic [ANCHO-1:0] op_q, op_d;
    logic [H-1:0]     raiz_q, raiz_d;
    logic [H:0]       rem_q, rem_d;
    logic [CW-1:0]    cuenta_q, cuenta_d;
    logic [H-1:0]     resultado_q, resultado_d;
    logic [H:0]       resto_q, resto_d;
    logic             terminado_q, terminado_d;
    logic             rechazado_q, rechazado_d;
    logic [31:0]      dout_q, dout_d;
    logic             irq_hab;

    logic wr, rd, wr_valor, wr_ctrl, inicio, ocupado;
    logic [H+2:0] parcial, prueba, dif;
    logic [H-1:0] raiz_n;
    logic [H:0]   rem_n;
    logic datos_unused;

    assign datos_unused = ^bus.entrada_datos;

    assign wr       = bus.habilitar & bus.escribir;
    assign rd       = bus.habilitar & bus.leer;
    assign wr_valor = wr && (bus.direccion == DIR_VALOR);
    assign wr_ctrl  = wr && (bus.direccion == DIR_CTRL);
    assign inicio   = wr_ctrl & bus.entrada_datos[0];
    assign ocupado  = (estado_q == CALCULO);

    // One restoring step: bring down the next two operand bits,
    // try subtracting 4*root+1.
    always_comb begin
        parcial = {rem_q, op_q[ANCHO-1 -: 2]};
        prueba  = {1'b0, raiz_q, 2'b01};
        dif     = parcial - prueba;
        if (parcial >= prueba) begin
            rem_n  = dif[H:0];
            raiz_n = {raiz_q[H-2:0], 1'b1};
        end else begin
            rem_n  = parcial[H:0];
            raiz_n = {raiz_q[H-2:0], 1'b0};
        end
    end

`ifdef RAIZ_IRQ_EN
    logic irq_hab_q, irq_hab_d, irq_q, wr_est;

    assign wr_est  = wr && (bus.direccion == DIR_EST);
    assign irq_hab = irq_hab_q;
    assign irq     = irq_q;

    always_comb begin
        irq_hab_d = irq_hab_q;
        if (wr_ctrl) irq_hab_d = bus.entrada_datos[1];
    end

    always_ff @(negedge reloj) begin
        if (reiniciar) begin
            irq_hab_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            irq_hab_q <= irq_hab_d;
            irq_q     <= terminado_q & irq_hab_q;
        end
    end
`else
    assign irq_hab = 1'b0;
`endif

    always_comb begin
        estado_d    = estado_q;
        valor_d     = valor_q;
        op_d        = op_q;
        raiz_d      = raiz_q;
        rem_d       = rem_q;
        cuenta_d    = cuenta_q;
        resultado_d = resultado_q;
        resto_d     = resto_q;
        terminado_d = terminado_q;
        rechazado_d = rechazado_q;
        dout_d      = dout_q;

        if (wr_valor) valor_d = bus.entrada_datos[ANCHO-1:0];

`ifdef RAIZ_IRQ_EN
        if (wr_est && bus.entrada_datos[0]) terminado_d = 1'b0;
`endif

        unique case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    estado_d    = CALCULO;
                    op_d        = valor_q;
                    raiz_d      = '0;
                    rem_d       = '0;
                    cuenta_d    = CW'(H);
                    terminado_d = 1'b0;
                    rechazado_d = 1'b0;
                end
            end
            CALCULO: begin
                op_d     = op_q << 2;
                raiz_d   = raiz_n;
                rem_d    = rem_n;
                cuenta_d = cuenta_q - CW'(1);
                if (inicio) rechazado_d = 1'b1;
                if (cuenta_q == CW'(1)) begin
                    estado_d    = REPOSO;
                    resultado_d = raiz_n;
                    resto_d     = rem_n;
                    terminado_d = 1'b1;
                end
            end
            default: estado_d = REPOSO;
        endcase

        // Read mux sees pre-edge register values.
        if (rd) begin
            unique case (1'b1)
                bus.direccion == DIR_VALOR: dout_d = 32'(valor_q);
                bus.direccion == DIR_CTRL:  dout_d = {30'd0, irq_hab, 1'b0};
                bus.direccion == DIR_RES:   dout_d = 32'(resultado_q);
                bus.direccion == DIR_EST:
                    dout_d = {29'd0, rechazado_q, ocupado, terminado_q};
                bus.direccion == DIR_RESTO: dout_d = 32'(resto_q);
                default:                    dout_d = '0;
            endcase
        end
    end

    always_ff @(negedge reloj) begin
        if (reiniciar) begin
            estado_q    <= REPOSO;
            valor_q     <= '0;
            op_q        <= '0;
            raiz_q      <= '0;
            rem_q       <= '0;
            cuenta_q    <= '0;
            resultado_q <= '0;
            resto_q     <= '0;
            terminado_q <= 1'b0;
            rechazado_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            estado_q    <= estado_d;
            valor_q     <= valor_d;
            op_q        <= op_d;
            raiz_q      <= raiz_d;
            rem_q       <= rem_d;
            cuenta_q    <= cuenta_d;
            resultado_q <= resultado_d;
            resto_q     <= resto_d;
            terminado_q <= terminado_d;
            rechazado_q <= rechazado_d;
            dout_q      <= dout_d;
        end
    end

    assign bus.salida_datos = dout_q;
endmodule

// File: tb/tb_periferico_raiz_param.sv
// Scoreboard bench for periferico_raiz_param (ANCHO=32): reads push
// expected data, a bus monitor pops and compares returned data.
module tb_periferico_raiz_param;
    localparam int H = 16;
    localparam logic [4:0] A_VALOR = 5'h04;
    localparam logic [4:0] A_CTRL  = 5'h0C;
    localparam logic [4:0] A_RES   = 5'h10;
    localparam logic [4:0] A_EST   = 5'h14;
    localparam logic [4:0] A_RESTO = 5'h18;
    localparam logic [4:0] A_NADA  = 5'h08;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] e;
    } esp_t;

    logic reloj = 1'b0;
    logic reiniciar = 1'b0;
    int   checks = 0;
    int   errors = 0;
    esp_t esperado[$];

    periferico_raiz_param_if #(.ANCHO_DIR(5)) bus_if ();

`ifdef RAIZ_IRQ_EN
    logic irq;
`endif

    periferico_raiz_param #(
        .ANCHO    (32),
        .ANCHO_DIR(5)
    ) dut (
        .reloj    (reloj),
        .reiniciar(reiniciar),
        .bus      (bus_if)
`ifdef RAIZ_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 reloj = ~reloj;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, act, exp);
        end
    endtask

    // Inputs change at posedge, DUT samples them at the next negedge.
    task automatic ciclo(input logic r, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] e);
        esp_t x;
        bus_if.habilitar     = r | w;
        bus_if.leer          = r;
        bus_if.escribir      = w;
        bus_if.direccion     = a;
        bus_if.entrada_datos = d;
        if (r) begin
            x.a = a;
            x.e = e;
            esperado.push_back(x);
        end
        @(posedge reloj);
        bus_if.habilitar = 1'b0;
        bus_if.leer      = 1'b0;
        bus_if.escribir  = 1'b0;
    endtask

    task automatic escribe(input logic [4:0] a, input logic [31:0] d);
        ciclo(1'b0, 1'b1, a, d, 32'd0);
    endtask

    task automatic lee(input logic [4:0] a, input logic [31:0] e);
        ciclo(1'b1, 1'b0, a, 32'd0, e);
    endtask

    task automatic espera(input int n);
        repeat (n) ciclo(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic reinicio(input int n);
        reiniciar = 1'b1;
        repeat (n) @(posedge reloj);
        reiniciar = 1'b0;
    endtask

    // Monitor: a read or reset seen at a negedge is checked half a cycle later.
    initial begin
        logic rd, rs;
        esp_t x;
        forever begin
            @(negedge reloj);
            rd = bus_if.habilitar & bus_if.leer;
            rs = reiniciar;
            @(posedge reloj);
            if (rs) begin
                chk("reset_dout", bus_if.salida_datos, 32'd0);
            end else if (rd) begin
                if (esperado.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read got %h expected none",
                             bus_if.salida_datos);
                end else begin
                    x = esperado.pop_front();
                    chk($sformatf("read_%02h", x.a), bus_if.salida_datos, x.e);
                end
            end
        end
    end

    initial begin
        bus_if.habilitar     = 1'b0;
        bus_if.leer          = 1'b0;
        bus_if.escribir      = 1'b0;
        bus_if.direccion     = '0;
        bus_if.entrada_datos = '0;
        @(posedge reloj);
        reinicio(2);

        // Reset state and unmapped read
        lee(A_VALOR, 32'd0);
        lee(A_RES, 32'd0);
        lee(A_EST, 32'd0);
        lee(A_RESTO, 32'd0);
        lee(A_NADA, 32'd0);
        escribe(A_NADA, 32'h1234);
        lee(A_NADA, 32'd0);

        // 144 with exact latency: busy at k+H, done at k+H+1
        escribe(A_VALOR, 32'd144);
        lee(A_VALOR, 32'd144);
        escribe(A_CTRL, 32'd1);
        espera(H - 1);
        lee(A_EST, 32'd2);
        lee(A_EST, 32'd1);
        lee(A_RES, 32'd12);
        lee(A_RESTO, 32'd0);

        // Zero operand
        escribe(A_VALOR, 32'd0);
        escribe(A_CTRL, 32'd1);
        espera(H + 1);
        lee(A_RES, 32'd0);
        lee(A_RESTO, 32'd0);

        // Maximum operand
        escribe(A_VALOR, 32'hFFFF_FFFF);
        escribe(A_CTRL, 32'd1);
        espera(H + 1);
        lee(A_RES, 32'h0000_FFFF);
        lee(A_RESTO, 32'h0001_FFFE);
        lee(A_EST, 32'd1);

        // Start while busy is rejected; old result held until completion
        escribe(A_VALOR, 32'd1000000);
        escribe(A_CTRL, 32'd1);
        espera(2);
        escribe(A_CTRL, 32'd1);
        lee(A_EST, 32'd6);
        espera(11);
        lee(A_RES, 32'h0000_FFFF);
        lee(A_EST, 32'd5);
        lee(A_RES, 32'd1000);
        lee(A_RESTO, 32'd0);

        // Accepted start clears rechazado and terminado
        escribe(A_CTRL, 32'd1);
        lee(A_EST, 32'd2);
        espera(H);
        lee(A_EST, 32'd1);

        // Reset mid-run
        escribe(A_VALOR, 32'd200);
        escribe(A_CTRL, 32'd1);
        espera(4);
        reinicio(1);
        lee(A_EST, 32'd0);
        lee(A_RES, 32'd0);
        lee(A_RESTO, 32'd0);
        lee(A_VALOR, 32'd0);
        escribe(A_VALOR, 32'd200);
        escribe(A_CTRL, 32'd1);
        espera(H + 1);
        lee(A_RES, 32'd14);
        lee(A_RESTO, 32'd4);
        lee(A_EST, 32'd1);

        // VALOR rewritten mid-run does not disturb the operand
        escribe(A_VALOR, 32'd50);
        escribe(A_CTRL, 32'd1);
        espera(3);
        escribe(A_VALOR, 32'd9);
        espera(H);
        lee(A_RES, 32'd7);
        lee(A_RESTO, 32'd1);
        lee(A_VALOR, 32'd9);
        escribe(A_CTRL, 32'd1);
        espera(H + 1);
        lee(A_RES, 32'd3);
        lee(A_RESTO, 32'd0);

        // Simultaneous read and write returns the pre-write value
        ciclo(1'b1, 1'b1, A_VALOR, 32'd77, 32'd9);
        lee(A_VALOR, 32'd77);

        // irq_hab visibility and ESTADO write behaviour
        lee(A_CTRL, 32'd0);
        escribe(A_CTRL, 32'd2);
`ifdef RAIZ_IRQ_EN
        lee(A_CTRL, 32'd2);
        escribe(A_EST, 32'd1);
        lee(A_EST, 32'd0);
`else
        lee(A_CTRL, 32'd0);
        escribe(A_EST, 32'd1);
        lee(A_EST, 32'd1);
`endif

`ifdef RAIZ_IRQ_EN
        escribe(A_VALOR, 32'd16);
        escribe(A_CTRL, 32'd3);
        espera(H + 2);
        chk("irq_raised", {31'd0, irq}, 32'd1);
        lee(A_RES, 32'd4);
        escribe(A_EST, 32'd1);
        espera(1);
        chk("irq_w1c", {31'd0, irq}, 32'd0);
        escribe(A_CTRL, 32'd1);
        espera(H + 2);
        chk("irq_disabled", {31'd0, irq}, 32'd0);
        lee(A_EST, 32'd1);
`endif

        espera(2);
        if (esperado.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_reads got %0d expected 0", esperado.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
